// File: rtl/csr_serial_bridge_if.sv
// Bundles the bridge's byte channels and register-file port.
// master: the bridge side (accepts rx bytes, sends tx bytes, drives the CSR port).
// slave : the environment side (byte source/sink and the register file).
//   rx_valid/rx_ready/rx_data : incoming byte stream
//   tx_valid/tx_ready/tx_data : outgoing byte stream
//   csr_addr/csr_wen/csr_wdata: register file address, write pulse, write data
//   csr_rdata                 : register file read data for csr_addr
interface csr_serial_bridge_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] csr_addr;
    logic              csr_wen;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, csr_rdata,
        output rx_ready, tx_valid, tx_data, csr_addr, csr_wen, csr_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, csr_rdata,
        input  rx_ready, tx_valid, tx_data, csr_addr, csr_wen, csr_wdata
    );
endinterface

// File: rtl/csr_serial_bridge.sv
// Byte-serial to CSR bridge. Decodes command frames (cmd byte, then 4 LSB-first
// data bytes for writes) into register-file writes, and answers read frames
// with 4 LSB-first bytes of the sampled read data.
//   clk   : sole clock
//   rst_n : synchronous active-low reset
//   bus   : byte channels and register-file port (master side)
//   busy  : high whenever the bridge is not idle
//   err   : sticky out-of-range address flag, cleared only by reset
module csr_serial_bridge #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    csr_serial_bridge_if.master         bus,
    output logic                        busy,
    output logic                        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    // Command address bits at or above ADDR_W flag an out-of-range access.
    localparam logic [6:0]  OOR_MASK = 7'(7'h7f << ADDR_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WDATA   = 3'd1,
        WCOMMIT = 3'd2,
        RSAMPLE = 3'd3,
        RSEND   = 3'd4
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                oor_q,      oor_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic                wen_q,      wen_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                rx_ready_q, rx_ready_d;
    logic                busy_q,     busy_d;
    logic                err_q,      err_d;

    logic                rx_hs;
    logic                tx_hs;

    assign rx_hs = bus.rx_valid & rx_ready_q;
    assign tx_hs = tx_valid_q & bus.tx_ready;

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        oor_d      = oor_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (rx_hs) begin
                    addr_d  = bus.rx_data[ADDR_W-1:0];
                    oor_d   = |(bus.rx_data[6:0] & OOR_MASK);
                    cnt_d   = '0;
                    state_d = bus.rx_data[7] ? WDATA : RSAMPLE;
                end
            end
            WDATA: begin
                if (rx_hs) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(3)) begin
                        state_d = WCOMMIT;
                    end
                end
            end
            WCOMMIT: begin
                if (oor_q) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            RSAMPLE: begin
                shift_d   = oor_q ? '0 : bus.csr_rdata;
                tx_data_d = shift_d[7:0];
                if (oor_q) begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = RSEND;
            end
            RSEND: begin
                if (tx_hs) begin
                    shift_d = shift_q >> 8;
                    cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(3)) begin
                        // Last byte: tx_data keeps its value once tx_valid drops.
                        state_d = IDLE;
                    end else begin
                        tx_data_d = shift_q[15:8];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake/status outputs follow the next state so they are flop outputs.
        rx_ready_d = (state_d == IDLE) || (state_d == WDATA);
        tx_valid_d = (state_d == RSEND);
        busy_d     = (state_d != IDLE);
        wen_d      = (state_d == WCOMMIT) && !oor_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oor_q      <= oor_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.csr_addr  = addr_q;
    assign bus.csr_wen   = wen_q;
    assign bus.csr_wdata = wdata_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_csr_serial_bridge.sv
// Directed bench for csr_serial_bridge with a frame-level reference model and
// a register-file model on the CSR port.
module tb_csr_serial_bridge;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NREG   = 64;

    logic clk;
    logic rst_n;
    logic busy;
    logic err;

    csr_serial_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    csr_serial_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file: combinational read, written by csr_wen or by bench preload.
    logic [31:0]       rf [NREG];
    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [31:0]       poke_data;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (poke_en) begin
            rf[poke_addr] <= poke_data;
        end else if (bus.csr_wen) begin
            rf[bus.csr_addr] <= bus.csr_wdata;
        end
    end
    assign bus.csr_rdata = rf[bus.csr_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [31:0] mm [NREG];
    logic [7:0]  frame [$];
    logic [7:0]  txq [$];
    logic [7:0]  got_tx [$];
    logic        wen_due, commit_due;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        err_exp, pend0, pend1;
    logic        prev_stall, prev_txv;
    logic [7:0]  prev_data;
    int          last_rx_cyc, txv_rise_cyc, wen_cyc, wen_cnt;

    // Frame-level model and per-cycle compare, sampled mid-cycle.
    initial begin
        wen_cnt = 0; last_rx_cyc = 0; txv_rise_cyc = 0; wen_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                frame.delete(); txq.delete();
                wen_due = 0; commit_due = 0; err_exp = 0; pend0 = 0; pend1 = 0;
                prev_stall = 0; prev_txv = 0; prev_data = '0;
                for (int i = 0; i < NREG; i++) mm[i] = '0;
            end else begin
                // err becomes visible two cycles after the frame-completing byte.
                err_exp = err_exp | pend1;
                pend1 = pend0;
                pend0 = 0;
                chk("err", 32'(err), 32'(err_exp));
                chk("csr_wen", 32'(bus.csr_wen), 32'(wen_due));
                if (wen_due) begin
                    chk("wen_addr", 32'(bus.csr_addr), 32'(exp_addr));
                    chk("wen_data", bus.csr_wdata, exp_wdata);
                end
                if (commit_due || txq.size() != 0)
                    chk("rx_ready_low", 32'(bus.rx_ready), 32'd0);
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.tx_valid), 32'd1);
                    chk("stall_data", 32'(bus.tx_data), 32'(prev_data));
                end
                if (bus.csr_wen) begin
                    wen_cnt++;
                    wen_cyc = cyc;
                end
                if (bus.tx_valid && !prev_txv) txv_rise_cyc = cyc;
                if (bus.tx_valid && bus.tx_ready) begin
                    if (txq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL tx_extra: got byte %02h expected none", bus.tx_data);
                    end else begin
                        chk("tx_byte", 32'(bus.tx_data), 32'(txq.pop_front()));
                    end
                    got_tx.push_back(bus.tx_data);
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_txv   = bus.tx_valid;
                prev_data  = bus.tx_data;
                wen_due = 0;
                commit_due = 0;
                if (poke_en) mm[poke_addr] = poke_data;
                if (bus.rx_valid && bus.rx_ready) begin
                    last_rx_cyc = cyc;
                    frame.push_back(bus.rx_data);
                    if (frame[0][7] && frame.size() == 5) begin
                        logic [6:0] a;
                        a = frame[0][6:0];
                        commit_due = 1;
                        if (int'(a) >= NREG) begin
                            pend0 = 1;
                        end else begin
                            exp_addr  = a[ADDR_W-1:0];
                            exp_wdata = {frame[4], frame[3], frame[2], frame[1]};
                            mm[exp_addr] = exp_wdata;
                            wen_due = 1;
                        end
                        frame.delete();
                    end else if (!frame[0][7]) begin
                        logic [6:0]  a;
                        logic [31:0] v;
                        a = frame[0][6:0];
                        if (int'(a) >= NREG) begin
                            v = '0;
                            pend0 = 1;
                        end else begin
                            v = mm[a[ADDR_W-1:0]];
                        end
                        for (int k = 0; k < 4; k++) txq.push_back(v[8*k +: 8]);
                        frame.delete();
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.rx_ready) done = 1;
        end
        @(posedge clk); #1;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL rx_timeout: byte %02h not accepted", b);
        end
    endtask

    task automatic send_write(input logic [7:0] cmd, input logic [31:0] d);
        send_byte(cmd);
        for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 100 && got_tx.size() < n; i++) @(negedge clk);
        if (got_tx.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL tx_timeout: got %0d bytes expected %0d", got_tx.size(), n);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_bytes(input string name, input logic [31:0] exp);
        for (int k = 0; k < 4; k++) begin
            if (k < got_tx.size()) chk(name, 32'(got_tx[k]), 32'(exp[8*k +: 8]));
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, wlast;
        logic [1:0] pat;
        rst_n = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b1;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;

        // Reset values.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_addr", 32'(bus.csr_addr), 32'd0);
        chk("rst_wen", 32'(bus.csr_wen), 32'd0);
        chk("rst_wdata", bus.csr_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rx_ready0", 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        chk("post_rst_rx_ready1", 32'(bus.rx_ready), 32'd1);
        @(posedge clk); #1;

        // Write 0x11223344 to addr 5 with rx_valid held high.
        w0 = wen_cnt;
        send_write(8'h85, 32'h11223344);
        wlast = last_rx_cyc;
        bus.rx_valid = 1'b0;
        idle(3);
        chk("wr_addr", 32'(bus.csr_addr), 32'd5);
        chk("wr_wdata", bus.csr_wdata, 32'h11223344);
        chk("wr_wen_count", 32'(wen_cnt - w0), 32'd1);
        chk("wr_wen_cycle", 32'(wen_cyc - wlast), 32'd1);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_rf", rf[5], 32'h11223344);

        // Read addr 5 returning 0xCAFEF00D.
        poke(6'd5, 32'hCAFEF00D);
        got_tx.delete();
        send_byte(8'h05);
        c0 = last_rx_cyc;
        bus.rx_valid = 1'b0;
        wait_tx(4);
        check_bytes("rd_bytes", 32'hCAFEF00D);
        chk("rd_latency", 32'(txv_rise_cyc - c0), 32'd2);
        chk("rd_tx_valid_low", 32'(bus.tx_valid), 32'd0);
        chk("rd_tx_data_hold", 32'(bus.tx_data), 32'hCA);

        // Same read under tx_ready pattern 1,0,0,1.
        got_tx.delete();
        send_byte(8'h05);
        bus.rx_valid = 1'b0;
        for (int k = 0; k < 60 && got_tx.size() < 4; k++) begin
            pat = 2'(k % 4);
            bus.tx_ready = (pat == 2'd0) || (pat == 2'd3);
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b1;
        wait_tx(4);
        check_bytes("bp_bytes", 32'hCAFEF00D);
        chk("bp_rx_ready_after", 32'(bus.rx_ready), 32'd1);

        // Out-of-range write and read.
        w0 = wen_cnt;
        send_write(8'hC1, 32'hDEADBEEF);
        bus.rx_valid = 1'b0;
        idle(3);
        chk("oor_wr_no_wen", 32'(wen_cnt - w0), 32'd0);
        chk("oor_wr_err", 32'(err), 32'd1);
        chk("oor_wr_rf1", rf[1], 32'd0);
        got_tx.delete();
        send_byte(8'h41);
        bus.rx_valid = 1'b0;
        wait_tx(4);
        check_bytes("oor_rd_bytes", 32'h00000000);
        idle(2);
        chk("oor_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a write frame.
        w0 = wen_cnt;
        send_byte(8'h82);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("mid_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_tx_data", 32'(bus.tx_data), 32'd0);
        chk("mid_addr", 32'(bus.csr_addr), 32'd0);
        chk("mid_wdata", bus.csr_wdata, 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        idle(4);
        chk("mid_no_wen", 32'(wen_cnt - w0), 32'd0);
        send_write(8'h83, 32'h0BADCAFE);
        bus.rx_valid = 1'b0;
        idle(3);
        chk("mid_wr3_rf", rf[3], 32'h0BADCAFE);
        chk("mid_wr3_wen", 32'(wen_cnt - w0), 32'd1);
        chk("mid_wr3_addr", 32'(bus.csr_addr), 32'd3);

        // Back-to-back write then read of addr 7.
        send_write(8'h87, 32'hA5A55A5A);
        wlast = last_rx_cyc;
        got_tx.delete();
        send_byte(8'h07);
        c0 = last_rx_cyc;
        bus.rx_valid = 1'b0;
        chk("b2b_cmd_cycle", 32'(c0 - wlast), 32'd2);
        wait_tx(4);
        check_bytes("b2b_bytes", 32'hA5A55A5A);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
